// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: recovers x/y/de, measures line/frame length, reports lock
// Optional no-hsync watchdog enabled by defining VGA_RX_TIMEOUT_EN.
module vga_sync_rx #(
  parameter int H_PIX        = 640,
  parameter int H_SYNC_PULSE = 96,
  parameter int H_FP         = 16,
  parameter int H_BP         = 48,
  parameter int V_PIX        = 480,
  parameter int V_SYNC_PULSE = 2,
  parameter int V_FP         = 10,
  parameter int V_BP         = 33,
  parameter int LOCK_LINES   = 4,
`ifdef VGA_RX_TIMEOUT_EN
  parameter int TIMEOUT_CYC  = 2 * (H_PIX + H_SYNC_PULSE + H_FP + H_BP),
`endif
  localparam int H_TOTAL = H_PIX + H_SYNC_PULSE + H_FP + H_BP,
  localparam int V_TOTAL = V_PIX + V_SYNC_PULSE + V_FP + V_BP,
  localparam int HW      = $clog2(H_TOTAL) + 1,
  localparam int VW      = $clog2(V_TOTAL) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs_i,
  input  logic          vs_i,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          de_o,
  output logic          locked_o,
  output logic [HW-1:0] line_len_o,
  output logic [VW-1:0] frame_len_o,
  output logic          err_o,
  output logic          no_sig_o
);

  localparam int HA = H_SYNC_PULSE + H_BP;
  localparam int VA = V_SYNC_PULSE + V_BP;
  localparam int MW = $clog2(LOCK_LINES + 1);

  localparam logic [HW-1:0] H_MAX     = '1;
  localparam logic [VW-1:0] V_MAX     = '1;
  localparam logic [HW-1:0] H_TOTAL_W = HW'(H_TOTAL);
  localparam logic [VW-1:0] V_TOTAL_W = VW'(V_TOTAL);
  localparam logic [HW-1:0] HA_W      = HW'(HA);
  localparam logic [HW-1:0] HE_W      = HW'(HA + H_PIX - 1);
  localparam logic [VW-1:0] VA_W      = VW'(VA);
  localparam logic [VW-1:0] VE_W      = VW'(VA + V_PIX - 1);
  localparam logic [MW-1:0] LOCK_W    = MW'(LOCK_LINES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } h_state_t;

  logic          hs_s1, hs_s2, hs_d;
  logic          vs_s1, vs_s2, vs_d;
  logic          hs_fall, vs_fall;
  logic [HW-1:0] h_cnt, h_len;
  logic [VW-1:0] v_cnt, v_len;
  h_state_t      h_state, h_state_nxt;
  logic [MW-1:0] match, match_nxt;
  logic          h_err, v_err;
  logic          v_armed, v_ok;
  logic          wd_expired;
  logic          h_in, v_in, win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s1 <= 1'b0;
      hs_s2 <= 1'b0;
      hs_d  <= 1'b0;
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_d  <= 1'b0;
    end else begin
      hs_s1 <= hs_i;
      hs_s2 <= hs_s1;
      hs_d  <= hs_s2;
      vs_s1 <= vs_i;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
    end
  end

  assign hs_fall = ~hs_s2 & hs_d;
  assign vs_fall = ~vs_s2 & vs_d;

  // Lengths saturate together with the counters so a stuck sync never wraps to a small value.
  assign h_len = (h_cnt == H_MAX) ? H_MAX : h_cnt + HW'(1);
  assign v_len = (v_cnt == V_MAX) ? V_MAX : v_cnt + VW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_len_o  <= '0;
      frame_len_o <= '0;
    end else begin
      if (hs_fall) begin
        h_cnt      <= '0;
        line_len_o <= h_len;
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (vs_fall) begin
        v_cnt       <= '0;
        frame_len_o <= v_len;
      end else if (hs_fall && (v_cnt != V_MAX)) begin
        v_cnt <= v_cnt + VW'(1);
      end
    end
  end

`ifdef VGA_RX_TIMEOUT_EN
  localparam int            WW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYC);

  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (hs_fall) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LIM) begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end

  assign wd_expired = (wd_cnt == WD_LIM);
`else
  assign wd_expired = 1'b0;
`endif

  assign no_sig_o = wd_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_state <= SEARCH;
      match   <= '0;
    end else begin
      h_state <= h_state_nxt;
      match   <= match_nxt;
    end
  end

  // A fall arriving while the watchdog is expired is treated as the first edge of a new search.
  always_comb begin
    h_state_nxt = h_state;
    match_nxt   = match;
    h_err       = 1'b0;
    if (wd_expired && !hs_fall) begin
      h_state_nxt = SEARCH;
      match_nxt   = '0;
    end else if (hs_fall) begin
      case (h_state)
        SEARCH: begin
          h_state_nxt = TRACK;
          match_nxt   = '0;
        end
        TRACK: begin
          if (h_len == H_TOTAL_W) begin
            match_nxt = match + MW'(1);
            if (match == LOCK_W - MW'(1)) begin
              h_state_nxt = LOCKED;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          if (h_len != H_TOTAL_W) begin
            h_err       = 1'b1;
            h_state_nxt = TRACK;
            match_nxt   = '0;
          end
        end
        default: begin
          h_state_nxt = SEARCH;
          match_nxt   = '0;
        end
      endcase
    end
  end

  // The first vsync after reset has no valid frame behind it, so it only arms the check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_armed <= 1'b0;
      v_ok    <= 1'b0;
    end else if (vs_fall) begin
      v_armed <= 1'b1;
      if (v_armed) begin
        v_ok <= (v_len == V_TOTAL_W);
      end
    end else if (wd_expired) begin
      v_ok <= 1'b0;
    end
  end

  assign locked_o = (h_state == LOCKED) & v_ok;
  assign v_err    = vs_fall & v_armed & locked_o & (v_len != V_TOTAL_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= h_err | v_err;
    end
  end

  assign h_in = (h_cnt >= HA_W) && (h_cnt <= HE_W);
  assign v_in = (v_cnt >= VA_W) && (v_cnt <= VE_W);
  assign win  = h_in & v_in;

  assign x_o  = win ? (h_cnt - HA_W) : '0;
  assign y_o  = win ? (v_cnt - VA_W) : '0;
  assign de_o = locked_o & win;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - directed bench for vga_sync_rx on a reduced 25x13 timing
// Builds with or without VGA_RX_TIMEOUT_EN.
module tb_vga_sync_rx;

  localparam int HT = 25;
  localparam int HS = 4;
  localparam int VS = 2;

  typedef struct {
    int v;
    int h;
    int de;
    int x;
    int y;
  } probe_t;

  typedef struct {
    int nlines;
    int bad_line;
    int bad_len;
    int probe;
    int exp_flen;
    int exp_lk0;
    int exp_lk_end;
    int exp_errs;
    int exp_ll0;
  } frame_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_i, vs_i;
  logic [5:0] x_o, line_len_o;
  logic [4:0] y_o, frame_len_o;
  logic       de_o, locked_o, err_o, no_sig_o;

  int total, bad;
  int err_seen, probe_hits;
  int last_l, last_len;
  int cap_ll, cap_lk, cap_fl, cap_ns;
  int r_flen, r_lk0, r_lk_end, r_ll0, r_ll_bad, r_lk_bad;

  probe_t     probes[8];
  frame_vec_t fvec[8];

  vga_sync_rx #(
    .H_PIX(16), .H_SYNC_PULSE(HS), .H_FP(2), .H_BP(3),
    .V_PIX(8), .V_SYNC_PULSE(VS), .V_FP(1), .V_BP(2),
    .LOCK_LINES(4)
  ) dut (
    .clk(clk), .rst(rst), .hs_i(hs_i), .vs_i(vs_i),
    .x_o(x_o), .y_o(y_o), .de_o(de_o), .locked_o(locked_o),
    .line_len_o(line_len_o), .frame_len_o(frame_len_o),
    .err_o(err_o), .no_sig_o(no_sig_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_probes(input int pv, input int ph);
    for (int i = 0; i < 8; i++) begin
      if (probes[i].v == pv && probes[i].h == ph) begin
        probe_hits++;
        chk($sformatf("probe%0d_de", i), int'(de_o), probes[i].de);
        chk($sformatf("probe%0d_x", i), int'(x_o), probes[i].x);
        chk($sformatf("probe%0d_y", i), int'(y_o), probes[i].y);
      end
    end
  endtask

  // Receiver h_cnt equals c-3 at the negedge of stimulus cycle c (two sync stages plus delay).
  task automatic run_line(input int len, input bit vs_lvl, input int l, input bit probe);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (err_o) err_seen++;
      if (c == 3) begin
        cap_ll = int'(line_len_o);
        cap_lk = int'(locked_o);
        cap_fl = int'(frame_len_o);
        cap_ns = int'(no_sig_o);
      end
      if (probe) check_probes((c >= 3) ? l : last_l, (c >= 3) ? c - 3 : c - 3 + last_len);
      hs_i = (c < HS) ? 1'b0 : 1'b1;
      vs_i = vs_lvl;
    end
    last_l   = l;
    last_len = len;
  endtask

  task automatic run_frame(input frame_vec_t f);
    err_seen = 0;
    r_ll_bad = 0;
    r_lk_bad = 0;
    for (int l = 0; l < f.nlines; l++) begin
      run_line((l == f.bad_line) ? f.bad_len : HT, (l < VS) ? 1'b0 : 1'b1, l, f.probe != 0);
      if (l == 0) begin
        r_flen = cap_fl;
        r_lk0  = cap_lk;
        r_ll0  = cap_ll;
      end
      if (l == f.bad_line + 1) begin
        r_ll_bad = cap_ll;
        r_lk_bad = cap_lk;
      end
      if (l == f.nlines - 1) r_lk_end = cap_lk;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    probe_hits = 0;
    last_l = -100;
    last_len = 0;
    rst = 1'b1;
    hs_i = 1'b1;
    vs_i = 1'b1;

    probes[0] = '{4, 7, 1, 0, 0};
    probes[1] = '{11, 22, 1, 15, 7};
    probes[2] = '{11, 23, 0, 0, 0};
    probes[3] = '{4, 6, 0, 0, 0};
    probes[4] = '{3, 7, 0, 0, 0};
    probes[5] = '{12, 7, 0, 0, 0};
    probes[6] = '{5, 10, 1, 3, 1};
    probes[7] = '{8, 15, 1, 8, 4};

    fvec[0] = '{13, -1, 0, 0, 1, 0, 0, 0, -1};
    fvec[1] = '{13, -1, 0, 0, 13, 1, 1, 0, 25};
    fvec[2] = '{13, -1, 0, 1, 13, 1, 1, 0, 25};
    fvec[3] = '{13, 5, 26, 0, 13, 1, 1, 1, 25};
    fvec[4] = '{13, -1, 0, 0, 13, 1, 1, 0, 25};
    fvec[5] = '{12, -1, 0, 0, 13, 1, 1, 0, 25};
    fvec[6] = '{13, -1, 0, 0, 12, 0, 0, 1, 25};
    fvec[7] = '{13, -1, 0, 0, 13, 1, 1, 0, 25};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs_i = 1'($urandom_range(0, 1));
      vs_i = 1'($urandom_range(0, 1));
      if (i % 5 == 4)
        chk("reset_outputs", int'({x_o, y_o, de_o, locked_o, line_len_o, frame_len_o, err_o, no_sig_o}), 0);
    end
    @(negedge clk);
    hs_i = 1'b1;
    vs_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(fvec[i]);
      chk($sformatf("f%0d_frame_len", i), r_flen, fvec[i].exp_flen);
      chk($sformatf("f%0d_lock_start", i), r_lk0, fvec[i].exp_lk0);
      chk($sformatf("f%0d_lock_end", i), r_lk_end, fvec[i].exp_lk_end);
      chk($sformatf("f%0d_err_pulses", i), err_seen, fvec[i].exp_errs);
      if (fvec[i].exp_ll0 >= 0) chk($sformatf("f%0d_line_len", i), r_ll0, fvec[i].exp_ll0);
      if (fvec[i].bad_line >= 0) begin
        chk($sformatf("f%0d_bad_line_len", i), r_ll_bad, fvec[i].bad_len);
        chk($sformatf("f%0d_bad_lock", i), r_lk_bad, 0);
      end
    end
    chk("probe_hits", probe_hits, 8);

    // hsync stuck high well past the watchdog limit
    hs_i = 1'b1;
    repeat (100) @(negedge clk);
`ifdef VGA_RX_TIMEOUT_EN
    chk("stuck_no_sig", int'(no_sig_o), 1);
    chk("stuck_lock", int'(locked_o), 0);
`else
    chk("stuck_no_sig", int'(no_sig_o), 0);
    chk("stuck_lock", int'(locked_o), 1);
`endif
    err_seen = 0;
    run_line(HT, 1'b1, 0, 1'b0);
    chk("post_stuck_line_len", cap_ll, 63);
    chk("post_stuck_lock", cap_lk, 0);
    chk("post_stuck_no_sig", cap_ns, 0);
`ifdef VGA_RX_TIMEOUT_EN
    chk("post_stuck_err", err_seen, 0);
`else
    chk("post_stuck_err", err_seen, 1);
`endif

    run_frame(fvec[1]);
    chk("relock_a_err", err_seen, 0);
    chk("relock_a_lock_end", r_lk_end, 0);
    run_frame(fvec[1]);
    chk("relock_b_lock_start", r_lk0, 1);
    chk("relock_b_lock_end", r_lk_end, 1);

    // asynchronous reset in the middle of a line
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hs_i = (c < HS) ? 1'b0 : 1'b1;
      vs_i = 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_lock", int'(locked_o), 0);
    chk("async_rst_line_len", int'(line_len_o), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(fvec[1]);
    chk("after_rst_lock_end", r_lk_end, 0);
    run_frame(fvec[1]);
    chk("after_rst_relock", r_lk0, 1);
    chk("after_rst_frame_len", r_flen, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
